uart_tx_arbiter: RTL

Round-robin scheduler that shares one `UART_TX` instance between `NUM_REQ` byte sources, such as a 7-segment status reporter, an RX echo path and a debug dump. It grants the transmitter to one requester for a whole frame, paces bytes with the transmitter's `o_TX_Active`/`o_TX_Done` handshake, and stops any requester from monopolising the line. It sits between the requesters and `UART_TX` (`i_TX_DV`, `i_TX_Byte`).

---
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// A grant covers a whole frame (or up to MAX_BURST bytes) and is paced by the TX Active/Done handshake.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 4096
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [NUM_REQ*8-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Busy,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned IDL_W = $clog2(IDLE_TIMEOUT);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic [IDL_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               last_q, last_d;
    logic               tx_dv_q, tx_dv_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               busy_q, busy_d;

    logic               own_dv;
    logic               own_last;
    logic [7:0]         own_byte;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic [IDX_W-1:0]   next_ptr;
    logic               release_grant;

    // Current owner's request lines.
    always_comb begin
        own_dv   = 1'b0;
        own_last = 1'b0;
        own_byte = 8'h00;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                own_dv   = i_Req_DV[k];
                own_last = i_Req_Last[k];
                own_byte = i_Req_Byte[8*k +: 8];
            end
        end
    end

    // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && i_Req_DV[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        ack_d         = '0;
        burst_cnt_d   = burst_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        last_d        = last_q;
        tx_dv_d       = 1'b0;
        tx_byte_d     = tx_byte_q;
        release_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|i_Req_DV) begin
                    owner_d     = pick;
                    grant_d     = NUM_REQ'(1) << pick;
                    burst_cnt_d = 8'd0;
                    idle_cnt_d  = '0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (own_dv) begin
                    // Never start a byte while the transmitter is still shifting one out.
                    if (!i_TX_Active) begin
                        tx_byte_d   = own_byte;
                        tx_dv_d     = 1'b1;
                        ack_d       = grant_q;
                        last_d      = own_last;
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        idle_cnt_d  = '0;
                        state_d     = ST_WAIT_DONE;
                    end
                end else if (idle_cnt_q == IDL_W'(IDLE_TIMEOUT - 1)) begin
                    release_grant = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDL_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (i_TX_Done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Absorbs a 2-cycle Done pulse so it counts once.
                if (!i_TX_Done && !i_TX_Active) begin
                    if (last_q || (burst_cnt_q == 8'(MAX_BURST))) begin
                        release_grant = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (release_grant) begin
            rr_ptr_d = next_ptr;
            grant_d  = '0;
            state_d  = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            burst_cnt_q <= 8'd0;
            idle_cnt_q  <= '0;
            last_q      <= 1'b0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            last_q      <= last_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            busy_q      <= busy_d;
        end
    end

    assign o_Req_Ack = ack_q;
    assign o_Grant   = grant_q;
    assign o_Busy    = busy_q;
    assign o_TX_DV   = tx_dv_q;
    assign o_TX_Byte = tx_byte_q;

endmodule
